intercal_alu_io: RTL and testbench

- Byte-serial front/back end for the 32-bit INTERCAL ALU on an 8-bit pin budget.
- Accepts a command frame on a valid/ready byte stream: one opcode byte, then operand a, then operand b when the opcode needs it.
- Drives the ALU's s/a/b inputs from held registers, captures the combinational result f, and streams it out as 4 bytes, LSB first.
- Sits directly upstream and downstream of the ALU inside the top-level wrapper.

---
 rtl/intercal_alu_io.sv | 112 +++++++++++
 tb/tb_intercal_alu_io.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/intercal_alu_io.sv
// Byte-serial command/result shell around the 32-bit INTERCAL ALU: opcode, operand a, optional operand b in; 4 result bytes out LSB first.
// One frame in flight; din_ready falls for CAPTURE/SEND, and dout holds while dout_ready is low.
module intercal_alu_io #(
   parameter logic [15:0] B_MASK         = 16'h0F02,
   parameter bit          CLEAR_ON_START = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic [7:0]  dout,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic [3:0]  alu_s,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_f,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CAPTURE, SEND} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [3:0]  s_q, s_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] res_q, res_d;
   logic        acc, ret;

   assign acc = din_valid & din_ready;
   assign ret = dout_valid & dout_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (acc) state_d = LOAD_A;
         LOAD_A:  if (acc && cnt_q == 2'd3) state_d = B_MASK[s_q] ? LOAD_B : CAPTURE;
         LOAD_B:  if (acc && cnt_q == 2'd3) state_d = CAPTURE;
         CAPTURE: state_d = SEND;
         SEND:    if (ret && cnt_q == 2'd3) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      din_ready  = (state_q == IDLE) || (state_q == LOAD_A) || (state_q == LOAD_B);
      dout_valid = (state_q == SEND);
      busy       = (state_q != IDLE);
      dout       = dout_valid ? res_q[{cnt_q, 3'b000} +: 8] : 8'h00;
   end

   // Operand registers drive the ALU directly, so they stay put from CAPTURE until the next opcode.
   always_comb begin
      cnt_d = cnt_q;
      s_d   = s_q;
      a_d   = a_q;
      b_d   = b_q;
      res_d = res_q;
      case (state_q)
         IDLE: if (acc) begin
            s_d   = din[3:0];
            cnt_d = 2'd0;
            if (CLEAR_ON_START) begin
               a_d = 32'h0;
               b_d = 32'h0;
            end
         end
         LOAD_A: if (acc) begin
            a_d[{cnt_q, 3'b000} +: 8] = din;
            cnt_d = cnt_q + 2'd1;
         end
         LOAD_B: if (acc) begin
            b_d[{cnt_q, 3'b000} +: 8] = din;
            cnt_d = cnt_q + 2'd1;
         end
         CAPTURE: begin
            res_d = alu_f;
            cnt_d = 2'd0;
         end
         SEND: if (ret) cnt_d = cnt_q + 2'd1;
         default: cnt_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 2'd0;
         s_q   <= 4'h0;
         a_q   <= 32'h0;
         b_q   <= 32'h0;
         res_q <= 32'h0;
      end else begin
         cnt_q <= cnt_d;
         s_q   <= s_d;
         a_q   <= a_d;
         b_q   <= b_d;
         res_q <= res_d;
      end
   end

   assign alu_s = s_q;
   assign alu_a = a_q;
   assign alu_b = b_q;

endmodule

// File: tb/tb_intercal_alu_io.sv
// Directed frames through intercal_alu_io with a behavioural ALU stand-in; a monitor pops expected result bytes from a scoreboard queue.
module tb_intercal_alu_io;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  din;
   logic        din_valid;
   logic        din_ready;
   logic [7:0]  dout;
   logic        dout_valid;
   logic        dout_ready;
   logic [3:0]  alu_s;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_f;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int ret_cnt = 0;
   logic [7:0] exp_q[$];

   intercal_alu_io dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .busy(busy)
   );

   always #5 clk = ~clk;

   // Stand-in ALU: op 2 is an arbitrary fixed mask so its result is easy to hand-check.
   function automatic logic [31:0] alu_model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      r = 32'h0;
      case (s)
         4'd0: r = a;
         4'd1: r = a | b;
         4'd2: r = a & 32'h00100010;
         4'd8: for (int i = 0; i < 16; i++) begin
                  r[2*i+1] = a[i];
                  r[2*i]   = b[i];
               end
         4'd9: r = a ^ b;
         4'd12, 4'd13, 4'd14, 4'd15: r = 32'h0;
         default: r = a + b;
      endcase
      return r;
   endfunction

   assign alu_f = alu_model(alu_s, alu_a, alu_b);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, req);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (din_valid && din_ready) acc_cnt++;
            if (dout_valid) begin
               check("din_ready_low_in_send", {31'h0, din_ready}, 32'h0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_dout actual %h required none", dout);
               end else if (dout_ready) begin
                  check("dout_byte", {24'h0, dout}, {24'h0, exp_q.pop_front()});
                  ret_cnt++;
               end else begin
                  check("dout_hold", {24'h0, dout}, {24'h0, exp_q[0]});
               end
            end
         end
      end
   end

   task automatic put_byte(input logic [7:0] v);
      int  n;
      bit  ok;
      n  = 0;
      ok = 1'b0;
      din       = v;
      din_valid = 1'b1;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = din_ready;
         @(posedge clk);
         #1;
         n++;
      end
      din_valid = 1'b0;
      if (!ok) check("din_accept_timeout", 32'h0, 32'h1);
   endtask

   task automatic idle_gap(input int gap);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit has_b, input int gap, input bit stall, input int exp_lat);
      logic [31:0] f;
      logic [31:0] beff;
      int acc0, ret0, lat, stall_left;
      beff = has_b ? b : 32'h0;
      f = alu_model(op[3:0], a, beff);
      for (int i = 0; i < 4; i++) exp_q.push_back(f[8*i +: 8]);
      acc0 = acc_cnt;
      ret0 = ret_cnt;
      put_byte(op);
      for (int i = 0; i < 4; i++) begin
         idle_gap(gap);
         put_byte(a[8*i +: 8]);
      end
      if (has_b) begin
         for (int i = 0; i < 4; i++) begin
            idle_gap(gap);
            put_byte(b[8*i +: 8]);
         end
      end
      check("alu_s_at_capture", {28'h0, alu_s}, {28'h0, op[3:0]});
      check("alu_a_at_capture", alu_a, a);
      check("alu_b_at_capture", alu_b, beff);
      lat = 0;
      stall_left = 3;
      while (busy && lat < 100) begin
         if (stall) begin
            din       = 8'hFF;
            din_valid = 1'b1;
         end
         @(posedge clk);
         #1;
         lat++;
         if (stall && dout_valid && (ret_cnt - ret0) == 2 && stall_left > 0) begin
            dout_ready = 1'b0;
            stall_left--;
         end else begin
            dout_ready = 1'b1;
         end
         if (!busy) din_valid = 1'b0;
      end
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      check("frame_latency", lat, exp_lat);
      check("busy_after_frame", {31'h0, busy}, 32'h0);
      check("dout_valid_after_frame", {31'h0, dout_valid}, 32'h0);
      check("bytes_consumed", acc_cnt - acc0, has_b ? 9 : 5);
      check("bytes_retired", ret_cnt - ret0, 4);
      idle_gap(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      din        = 8'h00;
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      idle_gap(3);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_dout_valid", {31'h0, dout_valid}, 32'h0);
      check("rst_din_ready", {31'h0, din_ready}, 32'h1);
      check("rst_dout", {24'h0, dout}, 32'h0);
      check("rst_alu_s", {28'h0, alu_s}, 32'h0);
      check("rst_alu_a", alu_a, 32'h0);
      check("rst_alu_b", alu_b, 32'h0);
      rst = 1'b0;
      idle_gap(2);

      run_frame(8'h00, 32'h12345678, 32'h0,        1'b0, 0, 1'b0, 5);
      run_frame(8'h01, 32'h00000000, 32'hDEADBEEF, 1'b1, 0, 1'b0, 5);
      run_frame(8'h08, 32'h0000FFFF, 32'h00000000, 1'b1, 0, 1'b0, 5);
      run_frame(8'h02, 32'h12345678, 32'h0,        1'b0, 0, 1'b0, 5);
      run_frame(8'h01, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b1, 1, 1'b1, 8);
      run_frame(8'h1C, 32'hFFFFFFFF, 32'h0,        1'b0, 0, 1'b0, 5);

      // Abort an op-9 frame two bytes into operand b.
      put_byte(8'h09);
      put_byte(8'h11);
      put_byte(8'h22);
      put_byte(8'h33);
      put_byte(8'h44);
      put_byte(8'h55);
      put_byte(8'h66);
      check("mid_frame_busy", {31'h0, busy}, 32'h1);
      rst = 1'b1;
      #1;
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_dout_valid", {31'h0, dout_valid}, 32'h0);
      check("abort_alu_a", alu_a, 32'h0);
      check("abort_alu_b", alu_b, 32'h0);
      check("abort_din_ready", {31'h0, din_ready}, 32'h1);
      idle_gap(2);
      rst = 1'b0;
      idle_gap(1);
      run_frame(8'h00, 32'h00000001, 32'h0, 1'b0, 0, 1'b0, 5);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
